lsu_align: RTL and testbench

Load/store unit in the execute-to-memory path: consumes the ALU `result` as the effective address, issues one data-memory transaction per accepted request, and returns lane-aligned, sign- or zero-extended load data to write-back. It is a single-outstanding, multi-cycle block. The pipeline stalls on `req_ready` low.

---
 rtl/lsu_align_if.sv | 42 ++++
 rtl/lsu_align.sv | 141 ++++++++++++++
 tb/tb_lsu_align.sv | 333 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lsu_align_if.sv
// Execute/memory/write-back signal bundle for lsu_align.
// The slave modport is the LSU; the master modport is its environment.
interface lsu_align_if #(
  parameter int SIZE = 64
);
  localparam int NB = SIZE / 8;

  logic            req_valid;
  logic            req_ready;
  logic            req_write;
  logic [1:0]      req_size;
  logic            req_unsigned;
  logic [SIZE-1:0] addr;
  logic [SIZE-1:0] wdata;

  logic            mem_valid;
  logic            mem_ready;
  logic            mem_write;
  logic [SIZE-1:0] mem_addr;
  logic [SIZE-1:0] mem_wdata;
  logic [NB-1:0]   mem_wstrb;
  logic            mem_rvalid;
  logic [SIZE-1:0] mem_rdata;

  logic            resp_valid;
  logic [SIZE-1:0] resp_data;
  logic            resp_error;

  modport slave (
    input  req_valid, req_write, req_size, req_unsigned, addr, wdata,
    input  mem_ready, mem_rvalid, mem_rdata,
    output req_ready, mem_valid, mem_write, mem_addr, mem_wdata, mem_wstrb,
    output resp_valid, resp_data, resp_error
  );

  modport master (
    output req_valid, req_write, req_size, req_unsigned, addr, wdata,
    output mem_ready, mem_rvalid, mem_rdata,
    input  req_ready, mem_valid, mem_write, mem_addr, mem_wdata, mem_wstrb,
    input  resp_valid, resp_data, resp_error
  );
endinterface

// File: rtl/lsu_align.sv
// Single-outstanding load/store unit: lane alignment of stores, extraction and extension of loads.
// Define LSU_MISALIGN_TRAP_EN to reject misaligned accesses instead of rounding the offset down.
module lsu_align #(
  parameter int SIZE = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  lsu_align_if.slave  bus
);
  localparam int NB = SIZE / 8;
  localparam int OW = $clog2(NB);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  state_t          state_reg, state_next;
  logic            req_ready_reg;
  logic            write_reg;
  logic            unsigned_reg;
  logic [1:0]      size_reg;
  logic [OW-1:0]   off_reg;
  logic [SIZE-1:0] maddr_reg;
  logic [SIZE-1:0] mwdata_reg;
  logic [NB-1:0]   wstrb_reg;
  logic [SIZE-1:0] rdata_reg;
  logic            error_reg;

  logic            accept;
  logic            illegal;
  logic            reject;
  logic [OW-1:0]   off;
  logic [OW-1:0]   size_mask;
  logic [OW-1:0]   eff_off;
  logic [NB-1:0]   lane_mask;
  logic [SIZE-1:0] rshift;
  logic [SIZE-1:0] load_ext;
  logic            top_bit;
  logic            fill;

  // req_ready_reg is low for one cycle after reset, so it gates acceptance as well.
  assign accept  = req_ready_reg & bus.req_valid;
  assign off     = bus.addr[OW-1:0];
  assign illegal = (SIZE == 32) && (bus.req_size == 2'b11);

  genvar gi;
  for (gi = 0; gi < OW; gi++) begin : g_size_mask
    assign size_mask[gi] = (gi < int'(bus.req_size));
  end
  for (gi = 0; gi < NB; gi++) begin : g_lane_mask
    assign lane_mask[gi] = (gi < (1 << bus.req_size));
  end

`ifdef LSU_MISALIGN_TRAP_EN
  logic misaligned;
  assign misaligned = |(off & size_mask);
  assign reject     = illegal | misaligned;
  assign eff_off    = off;
`else
  assign reject     = illegal;
  assign eff_off    = off & ~size_mask;
`endif

  assign rshift = bus.mem_rdata >> {off_reg, 3'b000};

  always_comb begin
    case (size_reg)
      2'b00:   top_bit = rshift[7];
      2'b01:   top_bit = rshift[15];
      2'b10:   top_bit = rshift[31];
      default: top_bit = rshift[SIZE-1];
    endcase
  end
  assign fill = top_bit & ~unsigned_reg;

  for (gi = 0; gi < SIZE; gi++) begin : g_load_ext
    assign load_ext[gi] = (gi < (8 << size_reg)) ? rshift[gi] : fill;
  end

  always_comb begin
    state_next     = state_reg;
    bus.mem_valid  = 1'b0;
    bus.resp_valid = 1'b0;
    case (state_reg)
      IDLE: if (accept) state_next = reject ? DONE : REQ;
      REQ: begin
        bus.mem_valid = 1'b1;
        if (bus.mem_ready) state_next = write_reg ? DONE : WAIT;
      end
      WAIT: if (bus.mem_rvalid) state_next = DONE;
      DONE: begin
        bus.resp_valid = 1'b1;
        state_next     = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      req_ready_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      req_ready_reg <= (state_next == IDLE);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      write_reg    <= 1'b0;
      unsigned_reg <= 1'b0;
      size_reg     <= 2'b00;
      off_reg      <= '0;
      maddr_reg    <= '0;
      mwdata_reg   <= '0;
      wstrb_reg    <= '0;
      rdata_reg    <= '0;
      error_reg    <= 1'b0;
    end else if (accept) begin
      write_reg    <= bus.req_write;
      unsigned_reg <= bus.req_unsigned;
      size_reg     <= bus.req_size;
      off_reg      <= eff_off;
      maddr_reg    <= {bus.addr[SIZE-1:OW], {OW{1'b0}}};
      mwdata_reg   <= bus.req_write ? (bus.wdata << {eff_off, 3'b000}) : '0;
      wstrb_reg    <= bus.req_write ? (lane_mask << eff_off) : '0;
      rdata_reg    <= '0;
      error_reg    <= reject;
    end else if (state_reg == WAIT && bus.mem_rvalid) begin
      rdata_reg <= load_ext;
    end
  end

  // Bus and response payloads are forced to zero outside the states that own them.
  assign bus.req_ready  = req_ready_reg;
  assign bus.mem_write  = (state_reg == REQ) & write_reg;
  assign bus.mem_addr   = (state_reg == REQ) ? maddr_reg : '0;
  assign bus.mem_wdata  = (state_reg == REQ) ? mwdata_reg : '0;
  assign bus.mem_wstrb  = (state_reg == REQ) ? wstrb_reg : '0;
  assign bus.resp_data  = (state_reg == DONE) ? rdata_reg : '0;
  assign bus.resp_error = (state_reg == DONE) & error_reg;
endmodule

// File: tb/tb_lsu_align.sv
// Self-checking bench for lsu_align: directed scenarios plus randomized ops against a byte-level model.
module tb_lsu_align;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int errors = 0;

  lsu_align_if #(.SIZE(64)) bus ();
  lsu_align_if #(.SIZE(32)) bus32 ();

  lsu_align #(.SIZE(64)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));
  lsu_align #(.SIZE(32)) dut32 (.clk(clk), .rst_n(rst_n), .bus(bus32.slave));

  always #5 clk = ~clk;

  // Observations from the most recent do_op call
  logic [63:0] r_addr, r_wdata, r_data;
  logic [7:0]  r_strb;
  bit          r_write, r_mv, r_stable, r_err, r_busy_low, r_ready_after, r_clear;
  int          r_hs, r_resp;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  task automatic idle_inputs();
    bus.req_valid = 0; bus.req_write = 0; bus.req_size = 0; bus.req_unsigned = 0;
    bus.addr = '0; bus.wdata = '0; bus.mem_ready = 0; bus.mem_rvalid = 0; bus.mem_rdata = '0;
    bus32.req_valid = 0; bus32.req_write = 0; bus32.req_size = 0; bus32.req_unsigned = 0;
    bus32.addr = '0; bus32.wdata = '0; bus32.mem_ready = 0; bus32.mem_rvalid = 0; bus32.mem_rdata = '0;
  endtask

  // Reference model: byte-lane arithmetic on the request as issued
  task automatic model(input bit wr, input logic [1:0] sz, input bit uns,
                       input logic [63:0] a, input logic [63:0] wd, input logic [63:0] rd,
                       output bit rej, output logic [63:0] e_addr, output logic [63:0] e_wdata,
                       output logic [63:0] e_data, output logic [7:0] e_strb);
    int nb, off, eoff;
    logic [63:0] keep, v;
    nb = 1 << sz;
    off = int'(a[2:0]);
    eoff = off - (off % nb);
`ifdef LSU_MISALIGN_TRAP_EN
    rej = (off % nb) != 0;
`else
    rej = 1'b0;
`endif
    e_addr = {a[63:3], 3'b000};
    e_wdata = wd << (8 * eoff);
    e_strb = wr ? 8'(((1 << nb) - 1) << eoff) : 8'h00;
    keep = (nb == 8) ? {64{1'b1}} : ((64'd1 << (8 * nb)) - 64'd1);
    v = (rd >> (8 * eoff)) & keep;
    if (!uns && nb < 8 && v[8 * nb - 1]) v = v | ~keep;
    e_data = (wr || rej) ? 64'd0 : v;
  endtask

  // Issues one op on the 64-bit DUT, plays memory, records what was observed
  task automatic do_op(input bit wr, input logic [1:0] sz, input bit uns,
                       input logic [63:0] a, input logic [63:0] wd, input logic [63:0] rd,
                       input int stall, input int rwait);
    int stall_left, wcnt, t;
    stall_left = stall; wcnt = 0; t = 0;
    r_addr = '0; r_wdata = '0; r_data = '0; r_strb = '0; r_write = 0;
    r_mv = 0; r_stable = 1; r_err = 0; r_busy_low = 1; r_hs = -1; r_resp = -1;
    while (!bus.req_ready && t < 20) begin @(negedge clk); t++; end
    bus.req_valid = 1; bus.req_write = wr; bus.req_size = sz; bus.req_unsigned = uns;
    bus.addr = a; bus.wdata = wd;
    @(negedge clk);
    bus.req_valid = 0; bus.addr = {$urandom, $urandom}; bus.wdata = {$urandom, $urandom};
    bus.req_size = 2'($urandom_range(0, 3)); bus.req_write = 1'($urandom_range(0, 1));
    bus.req_unsigned = 1'($urandom_range(0, 1));
    for (int c = 1; c <= 60 && r_resp < 0; c++) begin
      bus.mem_ready = 0; bus.mem_rvalid = 0; bus.mem_rdata = {$urandom, $urandom};
      if (bus.req_ready) r_busy_low = 0;
      if (bus.resp_valid) begin
        r_resp = c; r_data = bus.resp_data; r_err = bus.resp_error; bus.req_valid = 0;
      end else begin
        bus.req_valid = 1'($urandom_range(0, 1));
        if (bus.mem_valid) begin
          if (!r_mv) begin
            r_mv = 1; r_addr = bus.mem_addr; r_wdata = bus.mem_wdata;
            r_strb = bus.mem_wstrb; r_write = bus.mem_write;
          end else if (bus.mem_addr !== r_addr || bus.mem_wdata !== r_wdata ||
                       bus.mem_wstrb !== r_strb || bus.mem_write !== r_write) begin
            r_stable = 0;
          end
          bus.mem_rvalid = 1'($urandom_range(0, 1));
          if (stall_left > 0) stall_left--;
          else begin bus.mem_ready = 1; r_hs = c; end
        end else if (r_hs >= 0) begin
          if (wcnt == rwait) begin bus.mem_rvalid = 1; bus.mem_rdata = rd; end
          wcnt++;
        end
        @(negedge clk);
      end
    end
    bus.mem_ready = 0; bus.mem_rvalid = 0; bus.req_valid = 0;
    @(negedge clk);
    r_ready_after = bus.req_ready;
    r_clear = !bus.resp_valid && bus.resp_data == 0 && !bus.resp_error;
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if (bus.req_ready !== 1'b0 || bus32.req_ready !== 1'b0) begin
      errors++; $display("FAIL reset_ready: got %b/%b want 0/0", bus.req_ready, bus32.req_ready);
    end
    checks++;
    if (bus.mem_valid !== 1'b0 || bus.resp_valid !== 1'b0 || bus.mem_write !== 1'b0) begin
      errors++; $display("FAIL reset_valids: mem_valid=%b resp_valid=%b mem_write=%b want 0",
                         bus.mem_valid, bus.resp_valid, bus.mem_write);
    end
    checks++;
    if (bus.mem_addr !== '0 || bus.mem_wdata !== '0 || bus.mem_wstrb !== '0 ||
        bus.resp_data !== '0 || bus.resp_error !== 1'b0) begin
      errors++; $display("FAIL reset_data: addr=%h wdata=%h strb=%h rdata=%h err=%b want all 0",
                         bus.mem_addr, bus.mem_wdata, bus.mem_wstrb, bus.resp_data, bus.resp_error);
    end
    #2 rst_n = 1'b1;
    #1;
    checks++;
    if (bus.req_ready !== 1'b0) begin
      errors++; $display("FAIL ready_before_edge: got %b want 0", bus.req_ready);
    end
    @(negedge clk);
    checks++;
    if (bus.req_ready !== 1'b1 || bus32.req_ready !== 1'b1) begin
      errors++; $display("FAIL ready_after_edge: got %b/%b want 1/1", bus.req_ready, bus32.req_ready);
    end
  endtask

  task automatic test_signed_byte_load();
    do_op(0, 2'b00, 0, 64'h1003, 64'h0, 64'h0000_0000_8000_0000, 0, 0);
    checks++;
    if (r_addr !== 64'h1000) begin errors++; $display("FAIL sbyte_addr: got %h want 1000", r_addr); end
    checks++;
    if (r_strb !== 8'h00 || r_write !== 1'b0) begin
      errors++; $display("FAIL sbyte_strb: strb=%h write=%b want 00/0", r_strb, r_write);
    end
    checks++;
    if (r_data !== 64'hFFFF_FFFF_FFFF_FF80 || r_err !== 1'b0) begin
      errors++; $display("FAIL sbyte_data: got %h err=%b want ffffffffffffff80 err=0", r_data, r_err);
    end
    checks++;
    if (r_resp !== 3) begin errors++; $display("FAIL sbyte_latency: got %0d want 3", r_resp); end
    do_op(0, 2'b00, 1, 64'h1003, 64'h0, 64'h0000_0000_8000_0000, 0, 0);
    checks++;
    if (r_data !== 64'h80) begin errors++; $display("FAIL ubyte_data: got %h want 80", r_data); end
  endtask

  task automatic test_half_store_stall();
    do_op(1, 2'b01, 0, 64'h2006, 64'hBEEF, 64'h0, 3, 0);
    checks++;
    if (r_wdata !== 64'hBEEF_0000_0000_0000) begin
      errors++; $display("FAIL hstore_wdata: got %h want beef000000000000", r_wdata);
    end
    checks++;
    if (r_strb !== 8'hC0 || r_addr !== 64'h2000 || r_write !== 1'b1) begin
      errors++; $display("FAIL hstore_bus: strb=%h addr=%h write=%b want c0/2000/1", r_strb, r_addr, r_write);
    end
    checks++;
    if (r_stable !== 1'b1) begin errors++; $display("FAIL hstore_stable: got %b want 1", r_stable); end
    checks++;
    if (r_hs !== 4 || r_resp !== r_hs + 1) begin
      errors++; $display("FAIL hstore_timing: handshake=%0d resp=%0d want 4/5", r_hs, r_resp);
    end
    checks++;
    if (r_data !== 64'h0 || r_err !== 1'b0 || r_ready_after !== 1'b1 || r_clear !== 1'b1) begin
      errors++; $display("FAIL hstore_resp: data=%h err=%b ready=%b clear=%b want 0/0/1/1",
                         r_data, r_err, r_ready_after, r_clear);
    end
  endtask

  task automatic test_misaligned_word();
    do_op(0, 2'b10, 0, 64'h3002, 64'h0, 64'h1122_3344_5566_7788, 0, 0);
`ifdef LSU_MISALIGN_TRAP_EN
    checks++;
    if (r_mv !== 1'b0) begin errors++; $display("FAIL misw_trap_mem: mem_valid seen=%b want 0", r_mv); end
    checks++;
    if (r_err !== 1'b1 || r_data !== 64'h0 || r_resp !== 1) begin
      errors++; $display("FAIL misw_trap_resp: err=%b data=%h cycle=%0d want 1/0/1", r_err, r_data, r_resp);
    end
`else
    checks++;
    if (r_addr !== 64'h3000 || r_mv !== 1'b1) begin
      errors++; $display("FAIL misw_addr: got %h mv=%b want 3000/1", r_addr, r_mv);
    end
    checks++;
    if (r_data !== 64'h5566_7788 || r_err !== 1'b0) begin
      errors++; $display("FAIL misw_data: got %h err=%b want 55667788 err=0", r_data, r_err);
    end
`endif
  endtask

  task automatic test_reset_midop();
    // Store caught in REQ: mem_valid must drop as soon as reset asserts
    while (!bus.req_ready) @(negedge clk);
    bus.req_valid = 1; bus.req_write = 1; bus.req_size = 2'b11; bus.addr = 64'h6000; bus.wdata = 64'h1234;
    @(negedge clk);
    bus.req_valid = 0;
    checks++;
    if (bus.mem_valid !== 1'b1) begin errors++; $display("FAIL rstreq_pre: mem_valid=%b want 1", bus.mem_valid); end
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.mem_valid !== 1'b0) begin errors++; $display("FAIL rstreq_drop: mem_valid=%b want 0", bus.mem_valid); end
    @(negedge clk);
    #2 rst_n = 1'b1;
    // Load caught in WAIT, then spurious read data after release
    @(negedge clk);
    bus.req_valid = 1; bus.req_write = 0; bus.req_size = 2'b11; bus.addr = 64'h5000;
    @(negedge clk);
    bus.req_valid = 0; bus.mem_ready = 1;
    @(negedge clk);
    bus.mem_ready = 0;
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.mem_valid !== 1'b0 || bus.resp_valid !== 1'b0 || bus.req_ready !== 1'b0) begin
      errors++; $display("FAIL rstwait_in: mem_valid=%b resp_valid=%b req_ready=%b want 0/0/0",
                         bus.mem_valid, bus.resp_valid, bus.req_ready);
    end
    @(negedge clk);
    #2 rst_n = 1'b1;
    bus.mem_rvalid = 1; bus.mem_rdata = {$urandom, $urandom};
    @(negedge clk);
    bus.mem_rvalid = 0;
    checks++;
    if (bus.req_ready !== 1'b1 || bus.resp_valid !== 1'b0) begin
      errors++; $display("FAIL rstwait_release: req_ready=%b resp_valid=%b want 1/0", bus.req_ready, bus.resp_valid);
    end
    @(negedge clk);
    checks++;
    if (bus.resp_valid !== 1'b0 || bus.mem_valid !== 1'b0) begin
      errors++; $display("FAIL rstwait_spurious: resp_valid=%b mem_valid=%b want 0/0", bus.resp_valid, bus.mem_valid);
    end
  endtask

  task automatic test_random();
    bit wr, uns, rej;
    logic [1:0] sz;
    logic [63:0] a, wd, rd, e_addr, e_wdata, e_data;
    logic [7:0] e_strb;
    int stall, rwait, e_resp;
    for (int n = 0; n < 40; n++) begin
      wr = 1'($urandom_range(0, 1)); uns = 1'($urandom_range(0, 1)); sz = 2'($urandom_range(0, 3));
      a = {$urandom, $urandom}; wd = {$urandom, $urandom}; rd = {$urandom, $urandom};
      stall = $urandom_range(0, 2); rwait = $urandom_range(0, 2);
      model(wr, sz, uns, a, wd, rd, rej, e_addr, e_wdata, e_data, e_strb);
      do_op(wr, sz, uns, a, wd, rd, stall, rwait);
      e_resp = rej ? 1 : (wr ? stall + 2 : stall + 3 + rwait);
      $display("txn %0d wr=%0d sz=%0d uns=%0d addr=%h data=%h err=%0d cyc=%0d",
               n, wr, sz, uns, a, r_data, r_err, r_resp);
      checks++;
      if (r_data !== e_data || r_err !== rej) begin
        errors++; $display("FAIL rnd%0d_resp: data=%h err=%b want %h/%b", n, r_data, r_err, e_data, rej);
      end
      checks++;
      if (r_resp !== e_resp) begin errors++; $display("FAIL rnd%0d_latency: got %0d want %0d", n, r_resp, e_resp); end
      checks++;
      if (r_mv !== !rej || (!rej && (r_addr !== e_addr || r_strb !== e_strb || r_write !== wr))) begin
        errors++; $display("FAIL rnd%0d_bus: mv=%b addr=%h strb=%h write=%b want %b/%h/%h/%b",
                           n, r_mv, r_addr, r_strb, r_write, !rej, e_addr, e_strb, wr);
      end
      if (wr && !rej) begin
        checks++;
        if (r_wdata !== e_wdata) begin errors++; $display("FAIL rnd%0d_wdata: got %h want %h", n, r_wdata, e_wdata); end
      end
      checks++;
      if (r_stable !== 1'b1 || r_busy_low !== 1'b1 || r_ready_after !== 1'b1 || r_clear !== 1'b1) begin
        errors++; $display("FAIL rnd%0d_proto: stable=%b busy_low=%b ready_after=%b clear=%b want 1/1/1/1",
                           n, r_stable, r_busy_low, r_ready_after, r_clear);
      end
    end
  endtask

  task automatic test_size32();
    for (int w = 0; w < 2; w++) begin
      while (!bus32.req_ready) @(negedge clk);
      bus32.req_valid = 1; bus32.req_write = 1'(w); bus32.req_size = 2'b11; bus32.req_unsigned = 0;
      bus32.addr = 32'h4000; bus32.wdata = 32'hDEAD_BEEF;
      @(negedge clk);
      bus32.req_valid = 0;
      checks++;
      if (bus32.resp_valid !== 1'b1 || bus32.resp_error !== 1'b1 || bus32.resp_data !== '0 || bus32.mem_valid !== 1'b0) begin
        errors++; $display("FAIL s32_double%0d: resp_valid=%b err=%b data=%h mem_valid=%b want 1/1/0/0",
                           w, bus32.resp_valid, bus32.resp_error, bus32.resp_data, bus32.mem_valid);
      end
      @(negedge clk);
      checks++;
      if (bus32.resp_valid !== 1'b0 || bus32.resp_error !== 1'b0 || bus32.mem_valid !== 1'b0) begin
        errors++; $display("FAIL s32_double%0d_after: resp_valid=%b err=%b mem_valid=%b want 0/0/0",
                           w, bus32.resp_valid, bus32.resp_error, bus32.mem_valid);
      end
    end
    // Legal signed half load on the 32-bit datapath
    while (!bus32.req_ready) @(negedge clk);
    bus32.req_valid = 1; bus32.req_write = 0; bus32.req_size = 2'b01; bus32.addr = 32'h4002;
    @(negedge clk);
    bus32.req_valid = 0;
    checks++;
    if (bus32.mem_valid !== 1'b1 || bus32.mem_addr !== 32'h4000) begin
      errors++; $display("FAIL s32_half_bus: mem_valid=%b addr=%h want 1/4000", bus32.mem_valid, bus32.mem_addr);
    end
    bus32.mem_ready = 1;
    @(negedge clk);
    bus32.mem_ready = 0; bus32.mem_rvalid = 1; bus32.mem_rdata = 32'hABCD_1234;
    @(negedge clk);
    bus32.mem_rvalid = 0;
    checks++;
    if (bus32.resp_valid !== 1'b1 || bus32.resp_data !== 32'hFFFF_ABCD || bus32.resp_error !== 1'b0) begin
      errors++; $display("FAIL s32_half_data: resp_valid=%b data=%h err=%b want 1/ffffabcd/0",
                         bus32.resp_valid, bus32.resp_data, bus32.resp_error);
    end
    @(negedge clk);
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_signed_byte_load();
    test_half_store_stall();
    test_misaligned_word();
    test_size32();
    test_random();
    test_reset_midop();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
